// File: rtl/uart_mmio_bridge.sv
// MMIO bridge between the CPU data-memory port and the UART byte interface: TX/RX FIFOs,
// status/data registers and an optional cycle counter (enabled by UART_MMIO_COUNTERS_EN).
module uart_mmio_bridge #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [5:0] OFF_STATUS    = 6'h00;
    localparam logic [5:0] OFF_RX_DATA   = 6'h01;
    localparam logic [5:0] OFF_TX_DATA   = 6'h02;
    localparam logic [5:0] OFF_CYCLE     = 6'h04;
    localparam logic [5:0] OFF_CYCLE_RST = 6'h06;

    logic [5:0]    word;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          ovf;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_drop, ovf_clr;
    logic          rx_push, rx_pop;
    logic [31:0]   rd_next;
    logic [31:0]   cycle_val;
    logic          unused_bits;

    assign word        = mmio_addr[7:2];
    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

    // Full/empty come from the counts registered at the start of the cycle.
    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);

    assign tx_push = mmio_we && (word == OFF_TX_DATA) && !tx_full;
    assign tx_drop = mmio_we && (word == OFF_TX_DATA) && tx_full;
    assign tx_pop  = !tx_empty && tx_ready;
    assign ovf_clr = mmio_we && (word == OFF_STATUS) && mmio_wdata[2];
    assign rx_push = rx_valid && !rx_full;
    assign rx_pop  = mmio_re && (word == OFF_RX_DATA) && !rx_empty;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];
    assign rx_ready = !rx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);
            if (tx_drop)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);
        end
    end

    // FIFO storage is intentionally not reset; outputs are gated by the counts.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= mmio_wdata[7:0];
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
    end

`ifdef UART_MMIO_COUNTERS_EN
    logic [CNT_W-1:0] cycle_cnt;

    // A CYCLE_RST write wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (mmio_we && (word == OFF_CYCLE_RST)) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign cycle_val = 32'(cycle_cnt);
`else
    logic [CNT_W-1:0] unused_cycle;

    assign unused_cycle = '0;
    assign cycle_val    = 32'h0;
`endif

    always_comb begin
        rd_next = 32'h0;
        case (word)
            OFF_STATUS:  rd_next = {29'h0, ovf, !rx_empty, !tx_full};
            OFF_RX_DATA: rd_next = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr]};
            OFF_CYCLE:   rd_next = cycle_val;
            default:     rd_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_rdata <= 32'h0;
        end else if (mmio_re) begin
            mmio_rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed scenarios plus randomized traffic
// checked against a queue-based model of the register map and FIFOs.
module tb_uart_mmio_bridge;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mmio_addr = 8'h0;
    logic [31:0] mmio_wdata = 32'h0;
    logic        mmio_we = 1'b0;
    logic        mmio_re = 1'b0;
    logic [31:0] mmio_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    always #5 clk = ~clk;

    uart_mmio_bridge #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_we(mmio_we), .mmio_re(mmio_re),
        .mmio_rdata(mmio_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    int            n_checks = 0;
    int            n_pass = 0;
    byte unsigned  tx_q[$];
    byte unsigned  rx_q[$];
    bit            ovf = 1'b0;
    logic [31:0]   exp_rdata = 32'h0;
    int            edge_cnt = 0;
    int            last_crst = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // One bus cycle: drive, check outputs, advance the model by the register-map rules, clock.
    task automatic cyc(input bit we, input bit re, input logic [7:0] addr, input logic [31:0] wd,
                       input bit rxv, input logic [7:0] rxd, input bit txr);
        int unsigned tx_n, rx_n;
        logic [7:0]  a;
        mmio_we = we; mmio_re = re; mmio_addr = addr; mmio_wdata = wd;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        #1;
        tx_n = tx_q.size();
        rx_n = rx_q.size();
        a = addr & 8'hFC;
        check_eq("tx_valid", 32'(tx_valid), 32'(tx_n != 0));
        check_eq("tx_data", 32'(tx_data), (tx_n != 0) ? 32'(tx_q[0]) : 32'h0);
        check_eq("rx_ready", 32'(rx_ready), 32'(rx_n < DEPTH));
        if (re) begin
            if (a == 8'h00) exp_rdata = {29'h0, ovf, rx_n != 0, tx_n < DEPTH};
            else if (a == 8'h04) exp_rdata = (rx_n != 0) ? 32'(rx_q.pop_front()) : 32'h0;
`ifdef UART_MMIO_COUNTERS_EN
            else if (a == 8'h10) exp_rdata = 32'(edge_cnt - last_crst);
`endif
            else exp_rdata = 32'h0;
        end
        if (tx_n != 0 && txr) void'(tx_q.pop_front());
        if (we) begin
            if (a == 8'h08) begin
                if (tx_n < DEPTH) tx_q.push_back(wd[7:0]);
                else ovf = 1'b1;
            end else if (a == 8'h00 && wd[2]) begin
                ovf = 1'b0;
            end else if (a == 8'h18) begin
                last_crst = edge_cnt + 1;
            end
        end
        if (rxv && rx_n < DEPTH) rx_q.push_back(rxd);
        step();
        mmio_we = 1'b0;
        mmio_re = 1'b0;
        check_eq("mmio_rdata", mmio_rdata, exp_rdata);
    endtask

    task automatic idle(input int n, input bit txr);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 32'h0, 0, 8'h00, txr);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_q.delete();
        rx_q.delete();
        ovf = 1'b0;
        exp_rdata = 32'h0;
        edge_cnt = 0;
        last_crst = 0;
    endtask

    initial begin
        logic [7:0] addrs [8];
        logic [7:0] bytes [4];
        addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C;
        addrs[4] = 8'h10; addrs[5] = 8'h14; addrs[6] = 8'h18; addrs[7] = 8'h40;
        bytes[0] = 8'h78; bytes[1] = 8'h79; bytes[2] = 8'h7a; bytes[3] = 8'h0d;

        #1;
        check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_eq("rst_tx_data", 32'(tx_data), 32'h0);
        check_eq("rst_rx_ready", 32'(rx_ready), 32'h1);
        check_eq("rst_rdata", mmio_rdata, 32'h0);
        repeat (2) @(posedge clk);
        release_reset();

        // Status after reset, then two CYCLE reads spaced apart.
        cyc(0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        check_eq("status_after_reset", mmio_rdata, 32'h1);
        cyc(0, 1, 8'h10, 32'h0, 0, 8'h00, 0);
        idle(10, 0);
        cyc(0, 1, 8'h10, 32'h0, 0, 8'h00, 0);

        // Three TX bytes held, then drained in order.
        cyc(1, 0, 8'h08, 32'h31, 0, 8'h00, 0);
        cyc(1, 0, 8'h08, 32'h35, 0, 8'h00, 0);
        cyc(1, 0, 8'h08, 32'h31, 0, 8'h00, 0);
        idle(2, 0);
        idle(5, 1);

        // Overflow on the 9th byte, clear sticky, drain exactly 8.
        for (int i = 0; i < 9; i++) cyc(1, 0, 8'h08, 32'(8'h40 + i), 0, 8'h00, 0);
        cyc(0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        check_eq("status_overflow", mmio_rdata, 32'h4);
        cyc(1, 0, 8'h00, 32'h4, 0, 8'h00, 0);
        cyc(0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        idle(10, 1);

        // RX bytes read back in order, then an empty read.
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 32'h0, 1, bytes[i], 0);
        cyc(0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h04, 32'h0, 0, 8'h00, 0);
        check_eq("rx_empty_read", mmio_rdata, 32'h0);
        cyc(0, 1, 8'h00, 32'h0, 0, 8'h00, 0);

        // Fill RX, then read and push on the same cycle while full.
        for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, 32'h0, 1, 8'(8'h90 + i), 0);
        cyc(0, 1, 8'h04, 32'h0, 1, 8'hAA, 0);
        cyc(0, 0, 8'h00, 32'h0, 1, 8'hAA, 0);
        idle(2, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'h05, 32'h0, 0, 8'h00, 0);

        // Cycle counter reset.
        cyc(1, 0, 8'h18, 32'h0, 0, 8'h00, 0);
        idle(5, 0);
        cyc(0, 1, 8'h10, 32'h0, 0, 8'h00, 0);

        // Randomized traffic with varying handshake pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                int unsigned op;
                logic [7:0]  ad;
                bit          rxv, txr;
                op  = $urandom_range(0, 11);
                ad  = addrs[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
                rxv = ($urandom_range(0, 3) < ph + 1);
                txr = ($urandom_range(0, 3) >= ph);
                case (op)
                    0, 1, 2: cyc(1, 0, 8'h08 | 8'($urandom_range(0, 3)), $urandom, rxv, 8'($urandom), txr);
                    3:       cyc(0, 1, 8'h00, 32'h0, rxv, 8'($urandom), txr);
                    4, 5:    cyc(0, 1, 8'h04, 32'h0, rxv, 8'($urandom), txr);
                    6:       cyc(1, 0, 8'h00, $urandom, rxv, 8'($urandom), txr);
                    7:       cyc(0, 1, 8'h10, 32'h0, rxv, 8'($urandom), txr);
                    8:       cyc(($urandom_range(0, 7) == 0), 0, 8'h18, 32'h0, rxv, 8'($urandom), txr);
                    9:       cyc(1, 0, ad, $urandom, rxv, 8'($urandom), txr);
                    10:      cyc(0, 1, ad, 32'h0, rxv, 8'($urandom), txr);
                    default: cyc(0, 0, ad, 32'h0, rxv, 8'($urandom), txr);
                endcase
            end
        end

        // Asynchronous reset in the middle of a TX drain.
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h08, 32'(8'hC0 + i), 1, 8'h11, 0);
        cyc(0, 0, 8'h00, 32'h0, 0, 8'h00, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        check_eq("async_rst_tx_data", 32'(tx_data), 32'h0);
        check_eq("async_rst_rx_ready", 32'(rx_ready), 32'h1);
        check_eq("async_rst_rdata", mmio_rdata, 32'h0);
        repeat (2) @(posedge clk);
        release_reset();
        cyc(0, 1, 8'h00, 32'h0, 0, 8'h00, 1);
        check_eq("status_after_async_rst", mmio_rdata, 32'h1);
        cyc(1, 0, 8'h08, 32'h5A, 1, 8'h22, 0);
        idle(2, 1);
        cyc(0, 1, 8'h04, 32'h0, 0, 8'h00, 1);
        cyc(0, 1, 8'h10, 32'h0, 0, 8'h00, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
